// File: rtl/u_rec_param_if.sv
// Host-side register interface of the parametrised UART receiver: read strobe,
// held data word and per-frame status flags.
interface u_rec_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 rec_rdH;
  logic [DATA_BITS-1:0] rec_dataH;
  logic                 rec_validH;
  logic                 parity_errH;
  logic                 frame_errH;
  logic                 break_detH;
  logic                 overrun_errH;
  logic                 rec_busyH;

  // Host: issues reads and observes the holding register.
  modport master (
    output rec_rdH,
    input  rec_dataH, rec_validH, parity_errH, frame_errH, break_detH, overrun_errH, rec_busyH
  );

  // Receiver: owns the holding register and status.
  modport slave (
    input  rec_rdH,
    output rec_dataH, rec_validH, parity_errH, frame_errH, break_detH, overrun_errH, rec_busyH
  );
endinterface

// File: rtl/u_rec_param.sv
// Parametrised UART receiver. Oversamples the synchronised line on baud_tickH,
// votes 3 samples around mid-bit, and hands complete frames to a one-entry
// holding register with parity / framing / break / overrun status.
module u_rec_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0,
  parameter int STOP_BITS  = 1
) (
  input  logic          sys_clk,
  input  logic          sys_rstH,
  input  logic          baud_tickH,
  input  logic          uart_dataH,
  u_rec_param_if.slave  host
);
  localparam int M  = OVERSAMPLE / 2;
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [CW-1:0] C_LO  = CW'(M - 1);
  localparam logic [CW-1:0] C_MID = CW'(M);
  localparam logic [CW-1:0] C_HI  = CW'(M + 1);
  localparam logic [CW-1:0] C_END = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] B_LAST_STOP = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic                 sync1_q, sync2_q;
  state_t               state_q, state_d;
  logic [CW-1:0]        cntr_q, cntr_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 ferr_q, ferr_d;
  logic                 armed_q, armed_d;
  logic                 done_q, done_d;

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 fout_q, fout_d;
  logic                 brk_q, brk_d;
  logic                 ovr_q, ovr_d;

  logic line_s, vote_s, ferr_now_s, brk_now_s, perr_s, brk_s;

  assign line_s     = sync2_q;
  // Third sample is the live one; the first two were captured at M-1 and M.
  assign vote_s     = (smp_q[0] & smp_q[1]) | (smp_q[0] & line_s) | (smp_q[1] & line_s);
  assign ferr_now_s = ferr_q | ~vote_s;
  assign brk_now_s  = ferr_now_s & (shift_q == '0) & ~(PARITY_EN & par_q);
  assign perr_s     = PARITY_EN ? ((^shift_q ^ par_q) != PARITY_ODD) : 1'b0;
  assign brk_s      = ferr_q & (shift_q == '0) & ~(PARITY_EN & par_q);

  // Synchroniser, frame FSM state and datapath registers.
  always_ff @(posedge sys_clk or posedge sys_rstH) begin
    if (sys_rstH) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= S_IDLE;
      cntr_q  <= '0;
      bit_q   <= '0;
      smp_q   <= 2'b00;
      shift_q <= '0;
      par_q   <= 1'b0;
      ferr_q  <= 1'b0;
      armed_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sync1_q <= uart_dataH;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cntr_q  <= cntr_d;
      bit_q   <= bit_d;
      smp_q   <= smp_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      ferr_q  <= ferr_d;
      armed_q <= armed_d;
      done_q  <= done_d;
    end
  end

  // Frame FSM: tick-driven bit timing, majority sampling and bit assembly.
  always_comb begin
    state_d = state_q;
    cntr_d  = cntr_q;
    bit_d   = bit_q;
    smp_d   = smp_q;
    shift_d = shift_q;
    par_d   = par_q;
    ferr_d  = ferr_q;
    armed_d = armed_q;
    done_d  = 1'b0;
    if (baud_tickH) begin
      if (state_q != S_IDLE) begin
        cntr_d = (cntr_q == C_END) ? '0 : cntr_q + C_ONE;
        if (cntr_q == C_LO) smp_d[0] = line_s;
        else                smp_d[0] = smp_q[0];
        if (cntr_q == C_MID) smp_d[1] = line_s;
        else                 smp_d[1] = smp_q[1];
      end else begin
        cntr_d = '0;
      end
      case (state_q)
        S_IDLE: begin
          // After a break the line must go high once before a new start arms.
          if (line_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d = S_START;
            cntr_d  = C_ONE;
            ferr_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_START: begin
          if ((cntr_q == C_HI) && vote_s) begin
            state_d = S_IDLE;
            cntr_d  = '0;
          end else if (cntr_q == C_END) begin
            state_d = S_DATA;
            bit_d   = '0;
          end else begin
            state_d = S_START;
          end
        end
        S_DATA: begin
          if (cntr_q == C_HI) begin
            shift_d = {vote_s, shift_q[DATA_BITS-1:1]};
          end else if (cntr_q == C_END) begin
            if (bit_q == B_LAST_DATA) begin
              state_d = PARITY_EN ? S_PARITY : S_STOP;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end else begin
            shift_d = shift_q;
          end
        end
        S_PARITY: begin
          if (cntr_q == C_HI) begin
            par_d = vote_s;
          end else if (cntr_q == C_END) begin
            state_d = S_STOP;
            bit_d   = '0;
          end else begin
            par_d = par_q;
          end
        end
        S_STOP: begin
          if (cntr_q == C_HI) begin
            ferr_d = ferr_now_s;
            // Leave at mid last-stop so a back-to-back start can resync.
            if (bit_q == B_LAST_STOP) begin
              state_d = S_IDLE;
              cntr_d  = '0;
              done_d  = 1'b1;
              armed_d = ~brk_now_s;
            end else begin
              state_d = S_STOP;
            end
          end else if (cntr_q == C_END) begin
            bit_d = bit_q + BW'(1);
          end else begin
            bit_d = bit_q;
          end
        end
        default: begin
          state_d = S_IDLE;
          cntr_d  = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Holding register and status flags.
  always_ff @(posedge sys_clk or posedge sys_rstH) begin
    if (sys_rstH) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      fout_q  <= 1'b0;
      brk_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      fout_q  <= fout_d;
      brk_q   <= brk_d;
      ovr_q   <= ovr_d;
    end
  end

  // Load a completed frame, or clear valid/overrun on a host read.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    fout_d  = fout_q;
    brk_d   = brk_q;
    ovr_d   = ovr_q;
    if (done_q) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      perr_d  = perr_s;
      fout_d  = ferr_q;
      brk_d   = brk_s;
      // A read in the same cycle consumes the old word, so no overrun.
      if (valid_q && !host.rec_rdH) ovr_d = 1'b1;
      else if (valid_q)             ovr_d = 1'b0;
      else                          ovr_d = ovr_q;
    end else if (host.rec_rdH && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  assign host.rec_dataH    = data_q;
  assign host.rec_validH   = valid_q;
  assign host.parity_errH  = perr_q;
  assign host.frame_errH   = fout_q;
  assign host.break_detH   = brk_q;
  assign host.overrun_errH = ovr_q;
  assign host.rec_busyH    = (state_q != S_IDLE);
endmodule

// File: tb/tb_u_rec_param.sv
// Bench for u_rec_param: three receivers (8N1, 8E1, 7N2 at quarter tick rate)
// driven by a bit-level frame generator and checked against expected words and
// flags derived from the transmitted bits.
module tb_u_rec_param;
  localparam int OS = 16;
  typedef logic bitq_t[$];

  logic sys_clk = 1'b0;
  logic sys_rstH;
  logic tick_fast = 1'b1;
  logic tick2 = 1'b0;
  logic line0, line1, line2;
  int   total = 0;
  int   bad   = 0;
  int   vcnt0 = 0;
  logic v0_prev = 1'b0;

  always #5 sys_clk = ~sys_clk;

  u_rec_param_if #(.DATA_BITS(8)) if0 ();
  u_rec_param_if #(.DATA_BITS(8)) if1 ();
  u_rec_param_if #(.DATA_BITS(7)) if2 ();

  u_rec_param dut0 (.sys_clk(sys_clk), .sys_rstH(sys_rstH), .baud_tickH(tick_fast),
                    .uart_dataH(line0), .host(if0));
  u_rec_param #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut1 (.sys_clk(sys_clk), .sys_rstH(sys_rstH),
                    .baud_tickH(tick_fast), .uart_dataH(line1), .host(if1));
  u_rec_param #(.DATA_BITS(7), .STOP_BITS(2)) dut2 (.sys_clk(sys_clk), .sys_rstH(sys_rstH),
                    .baud_tickH(tick2), .uart_dataH(line2), .host(if2));

  // Baud tick for the third receiver: one strobe every 4th clock.
  initial begin
    int k = 0;
    forever begin
      @(posedge sys_clk); #1;
      tick2 = (k == 3);
      k = (k + 1) % 4;
    end
  end

  // Counts rising edges of rec_validH on the 8N1 receiver.
  always @(posedge sys_clk) begin
    v0_prev <= if0.rec_validH;
    if (if0.rec_validH && !v0_prev) vcnt0 <= vcnt0 + 1;
  end

  function automatic logic [5:0] st0();
    return {if0.rec_validH, if0.parity_errH, if0.frame_errH, if0.break_detH, if0.overrun_errH, if0.rec_busyH};
  endfunction
  function automatic logic [5:0] st1();
    return {if1.rec_validH, if1.parity_errH, if1.frame_errH, if1.break_detH, if1.overrun_errH, if1.rec_busyH};
  endfunction
  function automatic logic [5:0] st2();
    return {if2.rec_validH, if2.parity_errH, if2.frame_errH, if2.break_detH, if2.overrun_errH, if2.rec_busyH};
  endfunction

  function automatic bitq_t make_frame(input int nd, input logic [8:0] word, input bit pe,
                                       input logic pbit, input int ns, input logic [1:0] stops);
    bitq_t q;
    q.push_back(1'b0);
    for (int i = 0; i < nd; i++) q.push_back(word[i]);
    if (pe) q.push_back(pbit);
    for (int i = 0; i < ns; i++) q.push_back(stops[i]);
    return q;
  endfunction

  task automatic set_line(input int u, input logic b);
    case (u)
      0:       line0 = b;
      1:       line1 = b;
      default: line2 = b;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  // Drives the bits of a frame, each OS ticks long; optional 1-cycle low at mid-bit.
  task automatic send_bits(input int u, input bitq_t bits, input int glitch_bit);
    int len = OS * ((u == 2) ? 4 : 1);
    foreach (bits[i]) begin
      set_line(u, bits[i]);
      for (int c = 1; c < len; c++) begin
        @(posedge sys_clk); #1;
        if (i == glitch_bit && c == OS / 2) set_line(u, 1'b0);
        else                                set_line(u, bits[i]);
      end
      @(posedge sys_clk); #1;
    end
    set_line(u, 1'b1);
  endtask

  task automatic host_read(input int u);
    case (u)
      0:       if0.rec_rdH = 1'b1;
      1:       if1.rec_rdH = 1'b1;
      default: if2.rec_rdH = 1'b1;
    endcase
    @(posedge sys_clk); #1;
    if0.rec_rdH = 1'b0;
    if1.rec_rdH = 1'b0;
    if2.rec_rdH = 1'b0;
  endtask

  task automatic test_reset();
    sys_rstH = 1'b1;
    idle(3);
    total++; if ({if0.rec_dataH, st0()} !== 14'd0) begin bad++; $display("FAIL reset0: got %h want 0", {if0.rec_dataH, st0()}); end
    total++; if ({if1.rec_dataH, st1()} !== 14'd0) begin bad++; $display("FAIL reset1: got %h want 0", {if1.rec_dataH, st1()}); end
    total++; if ({if2.rec_dataH, st2()} !== 13'd0) begin bad++; $display("FAIL reset2: got %h want 0", {if2.rec_dataH, st2()}); end
    sys_rstH = 1'b0;
    idle(40);
  endtask

  task automatic test_latency();
    int n = 0;
    fork
      send_bits(0, make_frame(8, 9'h055, 1'b0, 1'b0, 1, 2'b11), -1);
      begin
        while (n < 400) begin
          @(posedge sys_clk); #1;
          if (if0.rec_validH === 1'b1) break;
          n++;
        end
      end
    join
    total++; if (n != 156) begin bad++; $display("FAIL latency: got %0d cycles want 156", n); end
    total++; if (if0.rec_dataH !== 8'h55) begin bad++; $display("FAIL lat_data: got %h want 55", if0.rec_dataH); end
    total++; if (st0() !== 6'b100000) begin bad++; $display("FAIL lat_flags: got %b want 100000", st0()); end
    host_read(0);
    total++; if ({if0.rec_validH, if0.rec_dataH} !== {1'b0, 8'h55}) begin bad++; $display("FAIL read_clear: got %h want 055", {if0.rec_validH, if0.rec_dataH}); end
  endtask

  task automatic test_parity();
    logic [7:0] w;
    logic       p, eperr;
    for (int i = 0; i < 8; i++) begin
      w = (i < 2) ? 8'hA3 : 8'($urandom_range(0, 255));
      p = (i < 2) ? 1'(i) : 1'($urandom_range(0, 1));
      eperr = (p != 1'($countones(w) % 2));
      send_bits(1, make_frame(8, {1'b0, w}, 1'b1, p, 1, 2'b11), -1);
      idle(8);
      total++;
      if ({if1.rec_dataH, st1()} !== {w, 1'b1, eperr, 4'b0000}) begin
        bad++; $display("FAIL parity%0d: got %h/%b want %h/%b", i, if1.rec_dataH, st1(), w, {1'b1, eperr, 4'b0000});
      end
      host_read(1);
    end
  endtask

  task automatic test_frame_break();
    int v0;
    send_bits(0, make_frame(8, 9'h03C, 1'b0, 1'b0, 1, 2'b00), -1);
    idle(2 * OS);
    total++; if ({if0.rec_dataH, st0()} !== {8'h3C, 6'b101000}) begin bad++; $display("FAIL stop0: got %h/%b want 3c/101000", if0.rec_dataH, st0()); end
    host_read(0);
    v0 = vcnt0;
    line0 = 1'b0;
    idle(12 * OS);
    line0 = 1'b1;
    idle(3 * OS);
    total++; if (vcnt0 - v0 != 1) begin bad++; $display("FAIL break_count: got %0d frames want 1", vcnt0 - v0); end
    total++; if ({if0.rec_dataH, st0()} !== {8'h00, 6'b101100}) begin bad++; $display("FAIL break: got %h/%b want 00/101100", if0.rec_dataH, st0()); end
    host_read(0);
  endtask

  task automatic test_glitch();
    int v0 = vcnt0;
    logic seen = 1'b0;
    line0 = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(posedge sys_clk); #1;
      if (c == 8) line0 = 1'b1;
      seen = seen | if0.rec_busyH;
    end
    total++; if ({seen, if0.rec_busyH} !== 2'b10) begin bad++; $display("FAIL glitch_busy: got seen/busy %b want 10", {seen, if0.rec_busyH}); end
    idle(3 * OS);
    total++; if ({vcnt0 - v0, if0.rec_validH} !== {32'd0, 1'b0}) begin bad++; $display("FAIL glitch_valid: got %0d frames valid=%b want 0", vcnt0 - v0, if0.rec_validH); end
    send_bits(0, make_frame(8, 9'h0A5, 1'b0, 1'b0, 1, 2'b11), 3);
    idle(8);
    total++; if ({if0.rec_dataH, st0()} !== {8'hA5, 6'b100000}) begin bad++; $display("FAIL vote_out: got %h/%b want a5/100000", if0.rec_dataH, st0()); end
    host_read(0);
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int m = 0;
    send_bits(0, make_frame(8, 9'h011, 1'b0, 1'b0, 1, 2'b11), -1);
    send_bits(0, make_frame(8, 9'h022, 1'b0, 1'b0, 1, 2'b11), -1);
    idle(8);
    total++; if ({if0.rec_dataH, st0()} !== {8'h22, 6'b100010}) begin bad++; $display("FAIL overrun: got %h/%b want 22/100010", if0.rec_dataH, st0()); end
    host_read(0);
    total++; if (st0() !== 6'b000000) begin bad++; $display("FAIL overrun_clear: got %b want 000000", st0()); end
    send_bits(0, make_frame(8, 9'h011, 1'b0, 1'b0, 1, 2'b11), -1);
    fork
      send_bits(0, make_frame(8, 9'h022, 1'b0, 1'b0, 1, 2'b11), -1);
      begin
        while (if0.rec_busyH !== 1'b1 && n < 400) begin @(posedge sys_clk); #1; n++; end
        while (if0.rec_busyH !== 1'b0 && m < 400) begin @(posedge sys_clk); #1; m++; end
        host_read(0);
      end
    join
    total++; if (n >= 400 || m >= 400) begin bad++; $display("FAIL b2b_timeout: got %0d/%0d want <400", n, m); end
    idle(8);
    total++; if ({if0.rec_dataH, st0()} !== {8'h22, 6'b100000}) begin bad++; $display("FAIL rd_coincident: got %h/%b want 22/100000", if0.rec_dataH, st0()); end
    host_read(0);
  endtask

  task automatic test_param7();
    logic [6:0] w;
    logic [1:0] s;
    logic       ef, eb;
    bitq_t      q;
    for (int i = 0; i < 6; i++) begin
      w  = (i == 0) ? 7'h5A : 7'($urandom_range(0, 127));
      s  = (i == 0 || $urandom_range(0, 2) != 0) ? 2'b11 : 2'($urandom_range(0, 2));
      ef = (s != 2'b11);
      eb = ef && (w == 7'd0);
      send_bits(2, make_frame(7, {2'b00, w}, 1'b0, 1'b0, 2, s), -1);
      idle(2 * OS * 4);
      total++;
      if ({if2.rec_dataH, st2()} !== {w, 1'b1, 1'b0, ef, eb, 2'b00}) begin
        bad++; $display("FAIL p7_%0d: got %h/%b want %h/%b", i, if2.rec_dataH, st2(), w, {1'b1, 1'b0, ef, eb, 2'b00});
      end
      host_read(2);
    end
    q = make_frame(7, 9'h02B, 1'b0, 1'b0, 2, 2'b11);
    send_bits(2, q[0:3], -1);
    line2 = q[4];
    idle(OS * 2);
    total++; if (if2.rec_busyH !== 1'b1) begin bad++; $display("FAIL midframe_busy: got %b want 1", if2.rec_busyH); end
    sys_rstH = 1'b1;
    #1;
    total++; if ({if2.rec_dataH, st2()} !== 13'd0) begin bad++; $display("FAIL midframe_reset: got %h want 0", {if2.rec_dataH, st2()}); end
    line2 = 1'b1;
    idle(3);
    sys_rstH = 1'b0;
    idle(2 * OS * 4);
    total++; if (st2() !== 6'b000000) begin bad++; $display("FAIL no_partial: got %b want 000000", st2()); end
    send_bits(2, make_frame(7, 9'h05A, 1'b0, 1'b0, 2, 2'b11), -1);
    idle(OS * 4);
    total++; if ({if2.rec_dataH, st2()} !== {7'h5A, 6'b100000}) begin bad++; $display("FAIL after_reset: got %h/%b want 5a/100000", if2.rec_dataH, st2()); end
  endtask

  initial begin
    sys_rstH = 1'b1;
    line0 = 1'b1;
    line1 = 1'b1;
    line2 = 1'b1;
    if0.rec_rdH = 1'b0;
    if1.rec_rdH = 1'b0;
    if2.rec_rdH = 1'b0;
    test_reset();
    test_latency();
    test_parity();
    test_frame_break();
    test_glitch();
    test_back_to_back();
    test_param7();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/u_rec_param.md
Name: u_rec_param

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver. It oversamples the serial line on an external baud-tick strobe and uses 3-sample majority voting per bit. Data width, parity mode and stop-bit count are configurable. It adds a one-entry holding register with a read handshake and per-frame parity, framing, break and overrun status. It sits between the pad-side uart_dataH line and the host register interface.

Parameters:
DATA_BITS, 8, data bits per frame, 5..9, LSB first
OVERSAMPLE, 16, baud ticks per bit, even, >=8
PARITY_EN, 0, 1 = parity bit follows data
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored if PARITY_EN=0)
STOP_BITS, 1, stop bits checked, 1 or 2

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rstH  in  1  asynchronous reset, active high
baud_tickH  in  1  one-cycle strobe at OVERSAMPLE x baud rate
uart_dataH  in  1  asynchronous serial input, idle high
rec_rdH  in  1  host read strobe, clears rec_validH and overrun_errH
rec_dataH  out  DATA_BITS  last received data word
rec_validH  out  1  level, a word is held and not yet read
parity_errH  out  1  parity error on the held word
frame_errH  out  1  a stop bit sampled 0 on the held word
break_detH  out  1  frame_errH, all data bits 0 and parity bit (if any) 0
overrun_errH  out  1  sticky, a word was overwritten before it was read
rec_busyH  out  1  state != IDLE

Behaviour:
- Clock and reset: single clock sys_clk. sys_rstH is asynchronous, active high. Reset clears all flops: sync flops = 1, state = IDLE, counters = 0, rec_dataH = 0, all status outputs = 0.
- Input sync: 2-flop synchroniser on uart_dataH, giving 2 cycles of latency. Only the synced signal is used.
- Ticks: the tick counter cntr advances only on cycles with baud_tickH=1. No state change occurs without a tick, except host-side flag updates.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a tick with synced line = 0, go to START with cntr = 1.
  - Sampling: M = OVERSAMPLE/2. Within each bit, samples are taken on the ticks where cntr = M-1, M and M+1. Bit value = majority of the 3 samples.
  - Bit boundary: a tick with cntr = OVERSAMPLE-1 sets cntr to 0 and moves to the next bit.
  - START: if the voted start bit = 1 (false start), return to IDLE at the cntr = M+1 tick. No outputs change.
  - DATA: DATA_BITS bits, LSB first, shifted into a shift register. A bit counter is cleared on entry from START.
  - PARITY: entered only if PARITY_EN=1.
  - STOP: STOP_BITS bits. Any stop bit voting 0 sets the frame-error flag.
  - Completion: at the cntr = M+1 tick of the last stop bit, go to IDLE. This allows resync on a back-to-back start bit during the second half of the stop bit.
- Completion update, next cycle:
  - rec_dataH = shift register, rec_validH = 1.
  - parity_errH, frame_errH and break_detH are loaded for the new frame.
- Parity check: even mode requires XOR(data, parity) = 0; odd mode requires 1. With PARITY_EN=0, parity_errH = 0 always.
- Read and overrun rules:
  - rec_rdH with rec_validH=1 clears rec_validH and overrun_errH on the next edge. Data and error flags are held.
  - If completion occurs while rec_validH=1 and rec_rdH=0, the word is overwritten and overrun_errH is set.
  - If completion and rec_rdH occur in the same cycle, the new word is loaded, rec_validH stays 1 and overrun_errH stays 0.
  - rec_rdH while rec_validH=0 has no effect.
- Latency: with baud_tickH tied high, rec_validH rises exactly 2 + ((1+DATA_BITS+PARITY_EN+STOP_BITS-1)*OVERSAMPLE + M+1) + 1 cycles after the falling edge on uart_dataH. For default 8N1 this is 156 cycles.
- Reset mid-frame: an immediate return to IDLE with outputs cleared. No partial word is ever reported.
- A line held low (break) completes one frame with break_detH=1. It does not restart until the synced line returns high, i.e. IDLE requires one high tick after a break before arming again.

Test Plan:
- Default params, ticks every cycle, send 0x55 8N1: rec_validH rises at cycle 156 with rec_dataH=0x55 and all error flags 0; rec_rdH clears rec_validH.
- PARITY_EN=1, PARITY_ODD=0, send 0xA3 with parity 0 then with parity 1: first frame parity_errH=0, second parity_errH=1; both give rec_dataH=0xA3.
- Stop bit forced 0 on 0x3C: frame_errH=1 and break_detH=0. Line held low 12 bit-times: rec_dataH=0x00, frame_errH=1, break_detH=1, and exactly one frame is reported.
- 8-cycle low glitch from idle (OVERSAMPLE=16): no rec_validH, rec_busyH returns to 0 by tick 10. A single-tick 0 at the sample point of a 1 data bit is voted out and the data is correct.
- Two back-to-back frames 0x11 and 0x22, never read: overrun_errH=1 and rec_dataH=0x22. Repeat with rec_rdH coincident with the second completion: overrun_errH=0 and rec_validH=1.
- DATA_BITS=7, STOP_BITS=2, baud_tickH every 4th cycle: 0x5A received correctly. Assert sys_rstH during bit 3 of a frame: all outputs 0 immediately and the next frame decodes normally.
